// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift/rotate register
// with saturating shift counter and done pulse.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_CLR  = 3'b110,
    M_INV  = 3'b111
  } mode_t;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             moved;
  logic             done_nxt;

  // Next word and count for the selected operation
  always_comb begin
    q_nxt   = q;
    cnt_nxt = shift_cnt;
    moved   = 1'b0;
    unique case (mode_t'(mode))
      M_HOLD: q_nxt = q;
      M_LOAD: begin
        q_nxt   = d;
        cnt_nxt = '0;
      end
      M_SHL: begin
        q_nxt = {q[WIDTH-2:0], sin_l};
        moved = 1'b1;
      end
      M_SHR: begin
        q_nxt = {sin_r, q[WIDTH-1:1]};
        moved = 1'b1;
      end
      M_ROL: begin
        q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        moved = 1'b1;
      end
      M_ROR: begin
        q_nxt = {q[0], q[WIDTH-1:1]};
        moved = 1'b1;
      end
      M_CLR: begin
        q_nxt   = RESET_VAL;
        cnt_nxt = '0;
      end
      M_INV: q_nxt = ~q;
      default: q_nxt = q;
    endcase
    if (moved && shift_cnt != CNT_MAX)
      cnt_nxt = shift_cnt + 1'b1;
    done_nxt = en && moved
             && shift_cnt == CNT_LAST;
  end

  // State register; async clear dominates
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_nxt;
      if (en) begin
        q         <= q_nxt;
        shift_cnt <= cnt_nxt;
      end
    end
  end

  assign qbar   = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed plan plus random
// stimulus against an arithmetic reference model.
module tb_shift_reg_univ;

  logic       clk;
  logic       clear_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] shift_cnt;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  int mq = 0;
  int mc = 0;
  int md = 0;

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk),
    .clear_n(clear_n),
    .en(en),
    .mode(mode),
    .d(d),
    .sin_l(sin_l),
    .sin_r(sin_r),
    .q(q),
    .qbar(qbar),
    .sout_l(sout_l),
    .sout_r(sout_r),
    .shift_cnt(shift_cnt),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(mq));
    chk({tag, ".qbar"}, 32'(qbar), 32'(255 - mq));
    chk({tag, ".sout_l"}, 32'(sout_l), 32'(mq / 128));
    chk({tag, ".sout_r"}, 32'(sout_r), 32'(mq % 2));
    chk({tag, ".cnt"}, 32'(shift_cnt), 32'(mc));
    chk({tag, ".done"}, 32'(done), 32'(md));
  endtask

  task automatic model(input bit e, input int m,
                       input int dd, input int sl,
                       input int sr);
    bit sh;
    sh = 0;
    md = 0;
    if (e) begin
      case (m)
        1: begin mq = dd; mc = 0; end
        2: begin mq = (mq * 2 + sl) % 256; sh = 1; end
        3: begin mq = mq / 2 + sr * 128; sh = 1; end
        4: begin mq = (mq * 2) % 256 + mq / 128; sh = 1; end
        5: begin mq = mq / 2 + (mq % 2) * 128; sh = 1; end
        6: begin mq = 0; mc = 0; end
        7: mq = 255 - mq;
        default: ;
      endcase
      if (sh) begin
        if (mc == 7) md = 1;
        if (mc < 8) mc++;
      end
    end
  endtask

  task automatic step(input string tag, input bit e,
                      input logic [2:0] m,
                      input logic [7:0] dd,
                      input bit sl, input bit sr);
    en = e;
    mode = m;
    d = dd;
    sin_l = sl;
    sin_r = sr;
    @(posedge clk);
    model(e, int'(m), int'(dd), int'(sl), int'(sr));
    #1;
    chk_all(tag);
  endtask

  task automatic async_rst(input string tag);
    #2 clear_n = 1'b0;
    mq = 0;
    mc = 0;
    md = 0;
    #1;
    chk_all(tag);
    #1 clear_n = 1'b1;
  endtask

  initial begin
    int pulses;
    logic [7:0] pat;
    clear_n = 1'b0;
    en = 1'b0;
    mode = 3'b000;
    d = 8'h00;
    sin_l = 1'b0;
    sin_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("por");
    clear_n = 1'b1;

    step("ld_a5", 1, 3'b001, 8'hA5, 0, 0);
    async_rst("arst");
    chk("arst_qbar", 32'(qbar), 32'hFF);
    step("ld_3c", 1, 3'b001, 8'h3C, 0, 0);
    chk("ld_3c_lit", 32'(q), 32'h3C);

    step("ld", 1, 3'b001, 8'hA5, 0, 0);
    step("shl1", 1, 3'b010, 8'h00, 1, 0);
    chk("shl1_lit", 32'(q), 32'h4B);
    chk("shl1_cnt", 32'(shift_cnt), 32'd1);
    step("ld", 1, 3'b001, 8'hA5, 0, 0);
    step("shr0", 1, 3'b011, 8'h00, 0, 0);
    chk("shr0_lit", 32'(q), 32'h52);
    step("ld", 1, 3'b001, 8'hA5, 0, 0);
    step("shr1", 1, 3'b011, 8'h00, 0, 1);
    chk("shr1_lit", 32'(q), 32'hD2);

    step("ld", 1, 3'b001, 8'h81, 0, 0);
    step("rol", 1, 3'b100, 8'h00, 0, 0);
    chk("rol_lit", 32'(q), 32'h03);
    step("ld", 1, 3'b001, 8'h81, 0, 0);
    step("ror", 1, 3'b101, 8'h00, 0, 0);
    chk("ror_lit", 32'(q), 32'hC0);
    step("ld", 1, 3'b001, 8'h81, 0, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step("rol8", 1, 3'b100, 8'h00, 0, 0);
      if (done === 1'b1) pulses++;
    end
    chk("rol8_lit", 32'(q), 32'h81);
    chk("rol8_pulses", 32'(pulses), 32'd1);

    step("ld", 1, 3'b001, 8'hA5, 0, 0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("ser_bit", 32'(sout_l), 32'(pat[7 - i]));
      step("ser", 1, 3'b010, 8'h00, 0, 0);
    end
    chk("ser_done", 32'(done), 32'd1);
    chk("ser_cnt", 32'(shift_cnt), 32'd8);
    step("ser9", 1, 3'b010, 8'h00, 0, 0);
    chk("ser9_cnt", 32'(shift_cnt), 32'd8);
    chk("ser9_done", 32'(done), 32'd0);

    step("en0", 0, 3'b001, 8'hFF, 0, 0);
    chk("en0_lit", 32'(q), 32'h00);
    step("ld", 1, 3'b001, 8'h87, 0, 0);
    step("rol", 1, 3'b100, 8'h00, 0, 0);
    step("inv", 1, 3'b111, 8'h00, 0, 0);
    chk("inv_lit", 32'(q), 32'hF0);
    chk("inv_cnt", 32'(shift_cnt), 32'd1);
    for (int i = 0; i < 3; i++)
      step("hold", 1, 3'b000, 8'hAA, 1, 1);
    chk("hold_lit", 32'(q), 32'hF0);

    step("ld", 1, 3'b001, 8'h11, 0, 0);
    for (int i = 0; i < 7; i++)
      step("pre", 1, 3'b011, 8'h00, 1, 1);
    chk("col_pre_cnt", 32'(shift_cnt), 32'd7);
    step("col_ld", 1, 3'b001, 8'h5A, 0, 0);
    chk("col_ld_lit", 32'(q), 32'h5A);
    chk("col_ld_done", 32'(done), 32'd0);
    for (int i = 0; i < 7; i++)
      step("pre", 1, 3'b101, 8'h00, 0, 0);
    step("col_clr", 1, 3'b110, 8'h00, 0, 0);
    chk("col_clr_lit", 32'(q), 32'h00);
    chk("col_clr_done", 32'(done), 32'd0);

    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 7) != 0),
           3'($urandom_range(0, 7)),
           8'($urandom),
           1'($urandom),
           1'($urandom));
      if ($urandom_range(0, 49) == 0)
        async_rst("rnd_arst");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register: the multi-bit, multi-mode successor to the single-bit D flip-flop with clear. It holds a WIDTH-bit word and on each enabled clock edge can hold, load, shift, rotate, clear or invert it. A shift counter and a done pulse let it act directly as a parallel-to-serial or serial-to-parallel converter. It sits between datapath registers and serial links in the EXP-series designs.

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- RESET_VAL, {WIDTH{1'b0}}, value of q after asynchronous reset and after sync-clear mode
- CW (localparam), $clog2(WIDTH+1), width of shift_cnt

- clk  in  1  rising-edge clock
- clear_n  in  1  asynchronous, active-low reset
- en  in  1  clock enable; 0 = everything holds
- mode  in  3  operation select (see Operation)
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial in, enters bit 0 on shift-left
- sin_r  in  1  serial in, enters bit WIDTH-1 on shift-right
- q  out  WIDTH  register contents
- qbar  out  WIDTH  ~q, combinational
- sout_l  out  1  q[WIDTH-1], combinational
- sout_r  out  1  q[0], combinational
- shift_cnt  out  CW  shifts/rotates since last load or clear, saturating at WIDTH
- done  out  1  one-cycle pulse, registered

## Operation
- clear_n = 0: q = RESET_VAL, shift_cnt = 0, done = 0 immediately, independent of clk. This applies mid-operation as well.
- Rising clk edge with en = 0: q and shift_cnt hold. done = 0.
- Rising clk edge with en = 1, by mode:
  - 000 hold: q holds, cnt holds
  - 001 load: q = d, cnt = 0
  - 010 shift left: q = {q[WIDTH-2:0], sin_l}, cnt += 1
  - 011 shift right: q = {sin_r, q[WIDTH-1:1]}, cnt += 1
  - 100 rotate left: q = {q[WIDTH-2:0], q[WIDTH-1]}, cnt += 1
  - 101 rotate right: q = {q[0], q[WIDTH-1:1]}, cnt += 1
  - 110 sync clear: q = RESET_VAL, cnt = 0
  - 111 invert: q = ~q, cnt holds
- shift_cnt saturates at WIDTH. Further shifts still move data, but cnt stays at WIDTH.
- done = 1 for exactly the one cycle after the edge on which cnt goes from WIDTH-1 to WIDTH. Otherwise done = 0.
- A load or sync clear on the same edge that would otherwise complete the count wins: cnt = 0, done = 0.
- qbar, sout_l and sout_r are pure functions of q. No extra latency.

## Timing
- Latency: q, shift_cnt and done update 1 clk after the enabled edge. Derived outputs follow q combinationally.
- Reset assertion is asynchronous.
- Reset release is sampled on clk. The first edge with clear_n = 1 performs a normal operation.
- Inputs (d, sin_l, sin_r, mode, en) must be stable around the rising edge. No input is sampled on the falling edge.
- Serialiser usage takes WIDTH+1 edges: 1 load, then WIDTH shifts. done appears in the cycle following the WIDTH-th shift.

## Test plan
All scenarios use WIDTH = 8 and RESET_VAL = 00.
- Reset: load A5, then drive clear_n = 0 between clock edges. Required response without waiting for an edge: q = 00, qbar = FF, shift_cnt = 0, done = 0. Then release clear_n and load 3C; q = 3C on the next edge.
- Shifts:
  - load A5, shift-left with sin_l = 1: q = 4B, cnt = 1
  - load A5, shift-right with sin_r = 0: q = 52
  - load A5, shift-right with sin_r = 1: q = D2
- Rotates:
  - load 81, rotate-left: q = 03
  - load 81, rotate-right: q = C0
  - after 8 rotate-lefts from 81: q = 81 and done pulsed once
- Serialiser:
  - load A5, then 8 shift-left edges. sout_l sampled before each shift reads 1,0,1,0,0,1,0,1.
  - done is high only after the 8th edge, with cnt = 8.
  - a 9th shift gives cnt = 8, done = 0.
- Enable and invert:
  - en = 0 with mode = 001, d = FF: q unchanged, done = 0
  - q = 0F, mode = 111: q = F0, cnt unchanged
  - mode = 000 for 3 edges: q constant
- Collision: with cnt = 7, apply mode = 001, d = 5A: q = 5A, cnt = 0, done stays 0. Then mode = 110: q = 00, cnt = 0.
